// File: rtl/grf_scoreboard.sv
// Parametrised register file with write bypass, two write ports, a per-register
// pending-write scoreboard for hazard stalls, and registered writeback trace outputs.
module grf_scoreboard #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2,
   parameter int PEND_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wa_en,
   input  logic [ADDR_W-1:0]          wa_addr,
   input  logic [DATA_W-1:0]          wa_data,
   input  logic [31:0]                wa_pc,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic [31:0]                wb_pc,
   input  logic                       iss_en,
   input  logic [ADDR_W-1:0]          iss_addr,
   output logic                       iss_ready,
   output logic                       err,
   output logic [1:0]                 trc_valid,
   output logic [63:0]                trc_pc,
   output logic [2*ADDR_W-1:0]        trc_addr,
   output logic [2*DATA_W-1:0]        trc_data
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [PEND_W-1:0] PMAX = '1;

   logic [DATA_W-1:0] mem       [DEPTH];
   logic [PEND_W-1:0] pend      [DEPTH];
   logic [PEND_W-1:0] pend_next [DEPTH];

   // Read ports: bypass from the writes being presented this cycle, A before B.
   for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              hit_a;
      logic              hit_b;
      logic [PEND_W+1:0] cur;
      logic [PEND_W+1:0] dec;
      assign a     = rd_addr[gi*ADDR_W +: ADDR_W];
      assign hit_a = wa_en && (wa_addr == a);
      assign hit_b = wb_en && (wb_addr == a);
      assign cur   = {2'b00, pend[a]};
      assign dec   = {{PEND_W{1'b0}}, 2'(hit_a) + 2'(hit_b)};
      assign rd_busy[gi] = (a != '0) && (cur > dec);
      assign rd_data[gi*DATA_W +: DATA_W] = (a == '0) ? '0 :
                                            hit_a     ? wa_data :
                                            hit_b     ? wb_data : mem[a];
   end

   // Per-register counter update: issue increments only below PMAX,
   // retirements decrement with a floor at zero.
   for (genvar gr = 0; gr < DEPTH; gr++) begin : g_pend
      logic              inc;
      logic [PEND_W+1:0] dec;
      logic [PEND_W+1:0] sum;
      assign inc = iss_en && (iss_addr == ADDR_W'(gr)) && (pend[gr] != PMAX);
      assign dec = {{PEND_W{1'b0}},
                    2'(wa_en && (wa_addr == ADDR_W'(gr))) +
                    2'(wb_en && (wb_addr == ADDR_W'(gr)))};
      assign sum = {2'b00, pend[gr]} + {{(PEND_W+1){1'b0}}, inc};
      if (gr == 0) begin : g_zero
         assign pend_next[gr] = '0;
      end else begin : g_nz
         assign pend_next[gr] = (sum > dec) ? PEND_W'(sum - dec) : '0;
      end
   end

   assign iss_ready = (iss_addr == '0) || (pend[iss_addr] != PMAX);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int r = 0; r < DEPTH; r++) begin
            mem[r]  <= '0;
            pend[r] <= '0;
         end
         err       <= 1'b0;
         trc_valid <= 2'b00;
         trc_pc    <= '0;
         trc_addr  <= '0;
         trc_data  <= '0;
      end else begin
         // B is written first so that A overrides it on an address collision.
         if (wb_en && (wb_addr != '0)) mem[wb_addr] <= wb_data;
         if (wa_en && (wa_addr != '0)) mem[wa_addr] <= wa_data;
         for (int r = 0; r < DEPTH; r++) pend[r] <= pend_next[r];
         if (iss_en && !iss_ready) err <= 1'b1;
         trc_valid <= {wb_en, wa_en};
         if (wa_en) begin
            trc_pc[31:0]            <= wa_pc;
            trc_addr[ADDR_W-1:0]    <= wa_addr;
            trc_data[DATA_W-1:0]    <= wa_data;
         end
         if (wb_en) begin
            trc_pc[63:32]               <= wb_pc;
            trc_addr[2*ADDR_W-1:ADDR_W] <= wb_addr;
            trc_data[2*DATA_W-1:DATA_W] <= wb_data;
         end
      end
   end

endmodule
